// File: rtl/vga_tty_pkg.sv
// Shared constants and FSM state type for the VGA tty writer.
// Optional CR/LF expansion is enabled by defining VGA_TTY_CRLF_EXPAND_EN.
package vga_tty_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef VGA_TTY_CRLF_EXPAND_EN
  typedef enum logic [1:0] {S_READY = 2'd0, S_GUARD = 2'd1, S_LF_PENDING = 2'd2} tty_state_e;
`else
  typedef enum logic [1:0] {S_READY = 2'd0, S_GUARD = 2'd1} tty_state_e;
`endif

endpackage

// File: rtl/vga_tty_fifo.sv
// Synchronous byte FIFO; a push while full is accepted only alongside a pop.
module vga_tty_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE   = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic                       do_push;
  logic                       do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vga_tty_writer.sv
// MMIO-fed tty producer: queues DATA bytes and strobes them into the console when not busy.
// Defining VGA_TTY_CRLF_EXPAND_EN sends each LF as CR then LF.
// Handshake: a tty_write pulse is issued only on an edge where tty_busy is low; after every
// pulse one GUARD cycle lets the console raise tty_busy before the next byte is considered.
module vga_tty_writer
  import vga_tty_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_addr,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        tty_write,
  output logic [7:0]  tty_data,
  input  logic        tty_busy,
  output logic [1:0]  fsm_state
);

  tty_state_e                state;
  tty_state_e                state_next;
  logic                      tty_write_next;
  logic [7:0]                tty_data_next;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic [7:0]                head;
  logic [FIFO_DEPTH_LOG2:0]  count;
  logic                      overflow;
  logic [31:0]               status;
  logic                      unused_wdata;
`ifdef VGA_TTY_CRLF_EXPAND_EN
  logic                      lf_owed;
  logic                      lf_owed_next;
`endif

  assign push         = bus_write && (bus_addr == ADDR_DATA);
  assign pop          = (state == S_READY) && !empty && !tty_busy;
  assign fsm_state    = state;
  assign unused_wdata = ^bus_wdata[31:8];

  vga_tty_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus_wdata[7:0]),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_READY;
      tty_write <= 1'b0;
      tty_data  <= 8'h00;
`ifdef VGA_TTY_CRLF_EXPAND_EN
      lf_owed   <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      tty_write <= tty_write_next;
      tty_data  <= tty_data_next;
`ifdef VGA_TTY_CRLF_EXPAND_EN
      lf_owed   <= lf_owed_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_READY: if (pop) state_next = S_GUARD;
`ifdef VGA_TTY_CRLF_EXPAND_EN
      S_GUARD:      state_next = lf_owed ? S_LF_PENDING : S_READY;
      S_LF_PENDING: if (!tty_busy) state_next = S_GUARD;
`else
      S_GUARD:      state_next = S_READY;
`endif
      default:      state_next = S_READY;
    endcase
  end

  always_comb begin
    tty_write_next = 1'b0;
    tty_data_next  = tty_data;
`ifdef VGA_TTY_CRLF_EXPAND_EN
    lf_owed_next   = lf_owed;
`endif
    case (state)
      S_READY: begin
        if (pop) begin
          tty_write_next = 1'b1;
          tty_data_next  = head;
`ifdef VGA_TTY_CRLF_EXPAND_EN
          // The LF leaves the FIFO now; only the owed flag remembers it.
          if (head == ASCII_LF) begin
            tty_data_next = ASCII_CR;
            lf_owed_next  = 1'b1;
          end
`endif
        end
      end
`ifdef VGA_TTY_CRLF_EXPAND_EN
      S_LF_PENDING: begin
        if (!tty_busy) begin
          tty_write_next = 1'b1;
          tty_data_next  = ASCII_LF;
          lf_owed_next   = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    status                                       = '0;
    status[ST_EMPTY]                             = empty;
    status[ST_FULL]                              = full;
    status[ST_OVERFLOW]                          = overflow;
    status[ST_BUSY]                              = tty_busy;
    status[ST_COUNT_LSB +: FIFO_DEPTH_LOG2 + 1]  = count;
  end

  // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      bus_rdata <= '0;
    end else begin
      if (bus_write && (bus_addr == ADDR_STATUS) && bus_wdata[ST_OVERFLOW]) overflow <= 1'b0;
      if (push && full && !pop) overflow <= 1'b1;
      if (bus_read) bus_rdata <= (bus_addr == ADDR_STATUS) ? status : 32'h0;
    end
  end

endmodule

// File: tb/tb_vga_tty_writer.sv
// Scoreboard bench for vga_tty_writer: expected bytes queued at stimulus, checked per pulse.
module tb_vga_tty_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_addr;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        tty_write;
  logic [7:0]  tty_data;
  logic        tty_busy;
  logic [1:0]  fsm_state;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic        busy_s = 1'b0;
  logic [7:0]  mon_exp;
  logic [7:0]  exp_q[$];
  int          pulse_cyc_q[$];

  always #5 clk = ~clk;

  vga_tty_writer #(.FIFO_DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_write (bus_write),
    .bus_read  (bus_read),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tty_write (tty_write),
    .tty_data  (tty_data),
    .tty_busy  (tty_busy),
    .fsm_state (fsm_state)
  );

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_s <= tty_busy;
  end

  // Monitor: every pulse must match the scoreboard head, respect busy and the 2-cycle spacing.
  always @(negedge clk) begin
    if (!reset && tty_write) begin
      pulses++;
      pulse_cyc_q.push_back(cyc);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL pulse_unexpected: got data=%02h, required no pulse", tty_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tty_data !== mon_exp) begin
          tests_failed++;
          $display("FAIL pulse_data: got %02h, required %02h", tty_data, mon_exp);
        end
      end
      tests_run++;
      if (busy_s) begin
        tests_failed++;
        $display("FAIL pulse_while_busy: got pulse with busy=1, required no pulse");
      end
      if (pulses > 1) begin
        tests_run++;
        if (cyc - last_cyc < 2) begin
          tests_failed++;
          $display("FAIL pulse_gap: got %0d cycles, required >= 2", cyc - last_cyc);
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic bus_wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus_addr  = a;
    bus_wdata = d;
    bus_write = 1'b1;
    @(negedge clk);
    bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a;
    bus_read = 1'b1;
    @(negedge clk);
    bus_read = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] st;
    tests_run++;
    if (tty_write !== 1'b0 || tty_data !== 8'h00 || bus_rdata !== 32'h0 || fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got write=%b data=%02h rdata=%08h state=%0d, required 0/00/0/0",
               tty_write, tty_data, bus_rdata, fsm_state);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL reset_status: got %08h, required 00000001", st);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] st;
    int p0 = pulses;
    exp_q.push_back(8'h41);
    bus_wr(1'b0, 32'h41);
    tests_run++;
    if (tty_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_early: got write=%b at E, required 0", tty_write);
    end
    @(negedge clk);
    tests_run++;
    if (tty_write !== 1'b1 || tty_data !== 8'h41) begin
      tests_failed++;
      $display("FAIL t1_latency: got write=%b data=%02h at E+1, required 1/41", tty_write, tty_data);
    end
    @(negedge clk);
    tests_run++;
    if (tty_write !== 1'b0 || tty_data !== 8'h41) begin
      tests_failed++;
      $display("FAIL t1_pulse_end: got write=%b data=%02h at E+2, required 0/41", tty_write, tty_data);
    end
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_0001 || pulses - p0 != 1) begin
      tests_failed++;
      $display("FAIL t1_status: got status=%08h pulses=%0d, required 00000001 and 1", st, pulses - p0);
    end
    bus_rd(1'b0, st);
    tests_run++;
    if (st !== 32'h0) begin
      tests_failed++;
      $display("FAIL data_read: got %08h, required 00000000", st);
    end
  endtask

  task automatic test_full_overflow();
    logic [31:0] st;
    int c0;
    tty_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      bus_wr(1'b0, 32'(i));
    end
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_100A) begin
      tests_failed++;
      $display("FAIL t2_full: got %08h, required 0000100a", st);
    end
    bus_wr(1'b0, 32'hFF);
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_100E) begin
      tests_failed++;
      $display("FAIL t2_overflow: got %08h, required 0000100e", st);
    end
    pulse_cyc_q.delete();
    @(negedge clk);
    tty_busy = 1'b0;
    c0 = cyc;
    wait_drain(100);
    tests_run++;
    if (pulse_cyc_q.size() != 16) begin
      tests_failed++;
      $display("FAIL t2_pulse_count: got %0d, required 16", pulse_cyc_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        tests_run++;
        if (pulse_cyc_q[i] != c0 + 1 + 2 * i) begin
          tests_failed++;
          $display("FAIL t2_timing: pulse %0d at cycle %0d, required %0d", i, pulse_cyc_q[i], c0 + 1 + 2 * i);
        end
      end
    end
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_0005) begin
      tests_failed++;
      $display("FAIL t2_sticky: got %08h, required 00000005", st);
    end
  endtask

  task automatic test_busy_stall();
    int n = 0;
    int p0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h60 + 8'(i));
      @(negedge clk);
      bus_addr  = 1'b0;
      bus_wdata = 32'h60 + 32'(i);
      bus_write = 1'b1;
    end
    @(negedge clk);
    bus_write = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!tty_write && n < 10);
    #2;
    tty_busy = 1'b1;
    p0 = pulses;
    repeat (5) @(negedge clk);
    tests_run++;
    if (pulses != p0) begin
      tests_failed++;
      $display("FAIL t3_stall: got %0d pulses while busy, required 0", pulses - p0);
    end
    tty_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tty_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL t3_resume: got write=%b on first free edge, required 1", tty_write);
    end
    wait_drain(50);
  endtask

  task automatic test_clear_and_full_pushpop();
    logic [31:0] st;
    bus_wr(1'b1, 32'h4);
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL t4_clear: got %08h, required 00000001", st);
    end
    tty_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      bus_wr(1'b0, 32'h20 + 32'(i));
    end
    exp_q.push_back(8'h77);
    @(negedge clk);
    bus_addr  = 1'b0;
    bus_wdata = 32'h77;
    bus_write = 1'b1;
    tty_busy  = 1'b0;
    @(negedge clk);
    bus_write = 1'b0;
    tty_busy  = 1'b1;
    bus_rd(1'b1, st);
    tests_run++;
    if (st !== 32'h0000_100A) begin
      tests_failed++;
      $display("FAIL t4_pushpop: got %08h, required 0000100a", st);
    end
    tty_busy = 1'b0;
    wait_drain(100);
  endtask

  task automatic test_lf();
    int p0 = pulses;
`ifdef VGA_TTY_CRLF_EXPAND_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(8'h0A);
`endif
    bus_wr(1'b0, 32'h0A);
    wait_drain(50);
    tests_run++;
`ifdef VGA_TTY_CRLF_EXPAND_EN
    if (pulses - p0 != 2) begin
      tests_failed++;
      $display("FAIL t5_lf_pulses: got %0d, required 2", pulses - p0);
    end
`else
    if (pulses - p0 != 1) begin
      tests_failed++;
      $display("FAIL t5_lf_pulses: got %0d, required 1", pulses - p0);
    end
`endif
  endtask

  task automatic test_reset_midpulse();
    logic [31:0] st;
    int p0;
    tty_busy = 1'b1;
    for (int i = 0; i < 6; i++) bus_wr(1'b0, 32'h50 + 32'(i));
    exp_q.push_back(8'h50);
    @(negedge clk);
    tty_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tty_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL t6_prepulse: got write=%b, required 1", tty_write);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (tty_write !== 1'b0 || tty_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL t6_async_drop: got write=%b data=%02h, required 0/00", tty_write, tty_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    p0 = pulses;
    repeat (10) @(negedge clk);
    bus_rd(1'b1, st);
    tests_run++;
    if (pulses != p0 || st !== 32'h0000_0001 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL t6_after_reset: got pulses=%0d status=%08h outstanding=%0d, required 0/00000001/0",
               pulses - p0, st, exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus_addr  = 1'b0;
    bus_write = 1'b0;
    bus_read  = 1'b0;
    bus_wdata = 32'h0;
    tty_busy  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_byte();
    test_full_overflow();
    test_busy_stall();
    test_clear_and_full_pushpop();
    test_lf();
    test_reset_midpulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200us, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
